// File: rtl/decode_stage.sv
// Registered RISC-V decode stage: field split, format-selected sign-extended immediate,
// illegal-encoding flag and pc passthrough. Define DECODE_SKID_EN for a registered-ready skid entry.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [PC_W-1:0]  pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  pc_out,
    output logic [4:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       func3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       func7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_cnt
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    logic [31:0]     src_inst;
    logic [PC_W-1:0] src_pc;
    logic            src_avail;
    logic            accept;
    logic            deliver;
    logic            out_free;
    logic            load;
    fmt_e            fmt_d;
    fmt_e            fmt_q;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;

    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

`ifdef DECODE_SKID_EN
    logic            skid_valid;
    logic [31:0]     skid_inst;
    logic [PC_W-1:0] skid_pc;

    // Ready comes straight from a flop; a buffered entry always wins over new input.
    assign in_ready  = !skid_valid;
    assign src_inst  = skid_valid ? skid_inst : inst;
    assign src_pc    = skid_valid ? skid_pc : pc_in;
    assign src_avail = skid_valid || accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && out_free) begin
            skid_valid <= 1'b0;
        end else if (accept && !out_free) begin
            skid_valid <= 1'b1;
            skid_inst  <= inst;
            skid_pc    <= pc_in;
        end
    end
`else
    assign in_ready  = !out_valid || out_ready;
    assign src_inst  = inst;
    assign src_pc    = pc_in;
    assign src_avail = accept;
`endif

    assign load = !flush && out_free && src_avail;

    always_comb begin
        fmt_d = FMT_ILL;
        if (src_inst[1:0] == 2'b11) begin
            case (src_inst[6:2])
                5'b01101, 5'b00101:                               fmt_d = FMT_U;
                5'b11011:                                         fmt_d = FMT_J;
                5'b11001, 5'b00000, 5'b00100, 5'b00011, 5'b11100: fmt_d = FMT_I;
                5'b01000:                                         fmt_d = FMT_S;
                5'b11000:                                         fmt_d = FMT_B;
                5'b01100:                                         fmt_d = FMT_R;
                5'b00110: if (XLEN == 64) fmt_d = FMT_I;
                5'b01110: if (XLEN == 64) fmt_d = FMT_R;
                default:                                          fmt_d = FMT_ILL;
            endcase
        end
    end

    always_comb begin
        imm32 = '0;
        case (fmt_d)
            FMT_I:   imm32 = {{20{src_inst[31]}}, src_inst[31:20]};
            FMT_S:   imm32 = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
            FMT_B:   imm32 = {{19{src_inst[31]}}, src_inst[31], src_inst[7],
                              src_inst[30:25], src_inst[11:8], 1'b0};
            FMT_U:   imm32 = {src_inst[31:12], 12'h000};
            FMT_J:   imm32 = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12],
                              src_inst[20], src_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Every 32-bit immediate is already sign-extended, so widening to XLEN is a signed cast.
        imm_d = XLEN'($signed(imm32));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pc_out    <= '0;
            opcode    <= '0;
            rd        <= '0;
            func3     <= '0;
            rs1       <= '0;
            rs2       <= '0;
            func7     <= '0;
            imm       <= '0;
            fmt_q     <= FMT_R;
            illegal   <= 1'b0;
            dec_cnt   <= '0;
        end else begin
            out_valid <= !flush && (out_free ? src_avail : 1'b1);
            if (load) begin
                pc_out  <= src_pc;
                opcode  <= src_inst[6:2];
                rd      <= src_inst[11:7];
                func3   <= src_inst[14:12];
                rs1     <= src_inst[19:15];
                rs2     <= src_inst[24:20];
                func7   <= src_inst[31:25];
                imm     <= imm_d;
                fmt_q   <= fmt_d;
                illegal <= (fmt_d == FMT_ILL);
            end
            if (deliver && !flush && dec_cnt != '1)
                dec_cnt <= dec_cnt + 1'b1;
        end
    end

    assign imm_fmt = fmt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default, XLEN=64 and CNT_W=2 instances share one stimulus stream.
module tb_decode_stage;

`ifdef DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] inst, pc_in;

    logic        in_ready, out_valid, illegal;
    logic [31:0] pc_out, imm;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [2:0]  func3, imm_fmt;
    logic [6:0]  func7;
    logic [15:0] dec_cnt;

    logic        in_ready_w, out_valid_w, illegal_w;
    logic [31:0] pc_out_w;
    logic [63:0] imm_w;
    logic [4:0]  opcode_w, rd_w, rs1_w, rs2_w;
    logic [2:0]  func3_w, imm_fmt_w;
    logic [6:0]  func7_w;
    logic [15:0] dec_cnt_w;

    logic        in_ready_c, out_valid_c, illegal_c;
    logic [31:0] pc_out_c, imm_c;
    logic [4:0]  opcode_c, rd_c, rs1_c, rs2_c;
    logic [2:0]  func3_c, imm_fmt_c;
    logic [6:0]  func7_c;
    logic [1:0]  dec_cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
        .func7(func7), .imm(imm), .imm_fmt(imm_fmt), .illegal(illegal), .dec_cnt(dec_cnt)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
        .inst(inst), .pc_in(pc_in), .out_valid(out_valid_w), .out_ready(out_ready),
        .pc_out(pc_out_w), .opcode(opcode_w), .rd(rd_w), .func3(func3_w), .rs1(rs1_w),
        .rs2(rs2_w), .func7(func7_w), .imm(imm_w), .imm_fmt(imm_fmt_w), .illegal(illegal_w),
        .dec_cnt(dec_cnt_w)
    );

    decode_stage #(.CNT_W(2)) dutc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
        .inst(inst), .pc_in(pc_in), .out_valid(out_valid_c), .out_ready(out_ready),
        .pc_out(pc_out_c), .opcode(opcode_c), .rd(rd_c), .func3(func3_c), .rs1(rs1_c),
        .rs2(rs2_c), .func7(func7_c), .imm(imm_c), .imm_fmt(imm_fmt_c), .illegal(illegal_c),
        .dec_cnt(dec_cnt_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p, input logic r);
        in_valid  = v;
        inst      = i;
        pc_in     = p;
        out_ready = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_imm", imm, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_dec_cnt", dec_cnt, 0);
        check("rst_imm_fmt", imm_fmt, 0);
        rst_n = 1'b1;

        // Streaming decode with out_ready=1.
        drive(1'b1, 32'hFFF00093, 32'h100, 1'b1); tick;
        check("addi_valid", out_valid, 1);
        check("addi_opcode", opcode, 5'b00100);
        check("addi_rd", rd, 1);
        check("addi_rs1", rs1, 0);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_fmt", imm_fmt, 1);
        check("addi_illegal", illegal, 0);
        check("addi_pc", pc_out, 32'h100);
        check("addi_imm64", imm_w, 64'hFFFFFFFFFFFFFFFF);

        drive(1'b1, 32'hFFDFF06F, 32'h104, 1'b1); tick;
        check("jal_cnt", dec_cnt, 1);
        check("jal_imm", imm, 32'hFFFFFFFC);
        check("jal_fmt", imm_fmt, 5);

        drive(1'b1, 32'h123452B7, 32'h108, 1'b1); tick;
        check("lui_imm", imm, 32'h12345000);
        check("lui_rd", rd, 5);
        check("lui_fmt", imm_fmt, 4);
        check("lui_cnt", dec_cnt, 2);

        drive(1'b1, 32'h800002B7, 32'h10C, 1'b1); tick;
        check("lui64_imm", imm_w, 64'hFFFFFFFF80000000);
        check("lui32_imm", imm, 32'h80000000);

        drive(1'b1, 32'h00000000, 32'h110, 1'b1); tick;
        check("zero_valid", out_valid, 1);
        check("zero_illegal", illegal, 1);
        check("zero_fmt", imm_fmt, 7);
        check("zero_imm", imm, 0);

        drive(1'b1, 32'h0000001B, 32'h114, 1'b1); tick;
        check("w32_illegal", illegal, 1);
        check("w32_fmt", imm_fmt, 7);
        check("w64_illegal", illegal_w, 0);
        check("w64_fmt", imm_fmt_w, 1);
        check("w_cnt", dec_cnt, 5);

        drive(1'b1, 32'hFE20AC23, 32'h118, 1'b1); tick;
        check("sw_imm", imm, 32'hFFFFFFF8);
        check("sw_fmt", imm_fmt, 2);
        check("sw_rs2", rs2, 2);
        check("sw_func3", func3, 2);

        drive(1'b1, 32'hFE000CE3, 32'h11C, 1'b1); tick;
        check("beq_imm", imm, 32'hFFFFFFF8);
        check("beq_fmt", imm_fmt, 3);

        drive(1'b1, 32'h402081B3, 32'h120, 1'b1); tick;
        check("sub_fmt", imm_fmt, 0);
        check("sub_imm", imm, 0);
        check("sub_func7", func7, 7'h20);
        check("sub_rd", rd, 3);
        check("sub_rs2", rs2, 2);

        drive(1'b1, 32'h00000010, 32'h124, 1'b1); tick;
        check("lowbits_illegal", illegal, 1);
        check("lowbits_fmt", imm_fmt, 7);

        drive(1'b0, 32'h0, 32'h0, 1'b1); tick;
        check("drain_valid", out_valid, 0);
        check("drain_cnt", dec_cnt, 10);

        // Backpressure: A held for three stalled cycles, then A and B in order.
        drive(1'b1, 32'h00100093, 32'h200, 1'b0); tick;
        check("bp_a_imm", imm, 1);
        check("bp_in_ready_e1", in_ready, SKID ? 1 : 0);
        drive(1'b1, 32'h00200113, 32'h204, 1'b0); tick;
        check("bp_in_ready_e2", in_ready, 0);
        check("bp_hold_imm_e2", imm, 1);
        if (SKID) in_valid = 1'b0;
        tick;
        check("bp_hold_pc_e3", pc_out, 32'h200);
        check("bp_in_ready_e3", in_ready, 0);
        tick;
        check("bp_hold_rd_e4", rd, 1);
        check("bp_hold_valid_e4", out_valid, 1);
        check("bp_hold_cnt_e4", dec_cnt, 10);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", in_ready, SKID ? 0 : 1);
        tick;
        in_valid = 1'b0;
        check("bp_b_valid", out_valid, 1);
        check("bp_b_imm", imm, 2);
        check("bp_b_pc", pc_out, 32'h204);
        check("bp_b_cnt", dec_cnt, 11);
        tick;
        check("bp_done_valid", out_valid, 0);
        check("bp_done_cnt", dec_cnt, 12);
        check("bp_done_ready", in_ready, 1);

        // Flush with output held and a second entry waiting.
        drive(1'b1, 32'h00100093, 32'h300, 1'b0); tick;
        drive(1'b1, 32'h00200113, 32'h304, 1'b0); tick;
        flush = 1'b1;
        drive(1'b1, 32'h00300193, 32'h308, 1'b1); tick;
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_cnt", dec_cnt, 12);
        check("fl_in_ready", in_ready, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b1); tick;
        check("fl_after_valid", out_valid, 0);
        check("fl_after_cnt", dec_cnt, 12);

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 32'h00100093, 32'h400, 1'b0); tick;
        drive(1'b0, 32'h0, 32'h0, 1'b0); tick;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_cnt", dec_cnt, 0);
        check("arst_cnt_c", dec_cnt_c, 0);
        check("arst_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;

        // Five deliveries: full counter reaches 5, 2-bit counter saturates at 3.
        drive(1'b1, 32'h00100093, 32'h500, 1'b1);
        repeat (5) tick;
        drive(1'b0, 32'h0, 32'h0, 1'b1); tick;
        check("sat_cnt", dec_cnt, 5);
        check("sat_cnt_c", dec_cnt_c, 3);
        check("sat_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
